vedic_mul8_seq: RTL and testbench

Sequential 8x8 unsigned multiplier controller. It time-shares a single combinational 4x4 Vedic multiplier core across the four nibble partial products of an 8-bit operand pair and accumulates them into a 16-bit product. It sits between a requesting datapath (start/operand handshake) and the 4x4 Vedic core. It trades four cycles of latency for one multiplier core instead of four.

---
 rtl/vedic_mul8_seq_pkg.sv | 31 +++
 rtl/vedic_mul4_comb.sv | 31 +++
 rtl/vedic_mul8_seq.sv | 123 ++++++++++++
 tb/tb_vedic_mul8_seq.sv | 228 ++++++++++++++++++++++
 4 files changed

// File: rtl/vedic_mul8_seq_pkg.sv
// Shared types for the sequential 8x8 Vedic multiplier: controller states and
// the nibble shift applied to each partial product.
package vedic_mul8_seq_pkg;

  typedef enum logic [2:0] {
    ST_IDLE = 3'd0,
    ST_P0   = 3'd1,
    ST_P1   = 3'd2,
    ST_P2   = 3'd3,
    ST_P3   = 3'd4,
    ST_DONE = 3'd5
  } state_e;

  localparam logic [3:0] SHIFT_P0 = 4'd0;
  localparam logic [3:0] SHIFT_P1 = 4'd4;
  localparam logic [3:0] SHIFT_P2 = 4'd4;
  localparam logic [3:0] SHIFT_P3 = 4'd8;

  function automatic logic [3:0] pp_shift(input state_e st);
    logic [3:0] sh;
    case (st)
      ST_P0:   sh = SHIFT_P0;
      ST_P1:   sh = SHIFT_P1;
      ST_P2:   sh = SHIFT_P2;
      ST_P3:   sh = SHIFT_P3;
      default: sh = 4'd0;
    endcase
    return sh;
  endfunction

endpackage

// File: rtl/vedic_mul4_comb.sv
// Combinational 4x4 unsigned multiplier built Urdhva-Tiryakbhyam style from
// four 2x2 vertical-and-crosswise blocks.
module vedic_mul4_comb (
  input  logic [3:0] a,
  input  logic [3:0] b,
  output logic [7:0] p
);

  function automatic logic [3:0] vedic2(input logic [1:0] x, input logic [1:0] y);
    logic cross_s;
    logic carry_s;
    logic top_s;
    cross_s = (x[1] & y[0]) ^ (x[0] & y[1]);
    carry_s = (x[1] & y[0]) & (x[0] & y[1]);
    top_s   = x[1] & y[1];
    return {top_s & carry_s, top_s ^ carry_s, cross_s, x[0] & y[0]};
  endfunction

  logic [3:0] q0_s;
  logic [3:0] q1_s;
  logic [3:0] q2_s;
  logic [3:0] q3_s;

  assign q0_s = vedic2(a[1:0], b[1:0]);
  assign q1_s = vedic2(a[3:2], b[1:0]);
  assign q2_s = vedic2(a[1:0], b[3:2]);
  assign q3_s = vedic2(a[3:2], b[3:2]);

  assign p = {4'b0000, q0_s} + {2'b00, q1_s, 2'b00} + {2'b00, q2_s, 2'b00} + {q3_s, 4'b0000};

endmodule

// File: rtl/vedic_mul8_seq.sv
// Sequential 8x8 unsigned multiplier: one 4x4 Vedic core is reused over four
// cycles, one nibble partial product per cycle, accumulated into 16 bits.
module vedic_mul8_seq
  import vedic_mul8_seq_pkg::*;
(
  input  logic        clk_i,
  input  logic        rst_i,
  input  logic        start_i,
  input  logic        abort_i,
  input  logic [7:0]  a_i,
  input  logic [7:0]  b_i,
  output logic        busy_o,
  output logic        done_o,
  output logic [15:0] product_o
);

  state_e      state_q, state_d;
  logic [7:0]  a_q, a_d;
  logic [7:0]  b_q, b_d;
  logic [15:0] acc_q, acc_d;
  logic [15:0] product_q, product_d;
  logic        done_q, done_d;

  logic [3:0]  core_a_s;
  logic [3:0]  core_b_s;
  logic [7:0]  pp_s;
  logic [15:0] acc_sum_s;

  // Nibble pair fed to the shared core in each phase.
  always_comb begin
    core_a_s = 4'h0;
    core_b_s = 4'h0;
    case (state_q)
      ST_P0:   begin core_a_s = a_q[3:0]; core_b_s = b_q[3:0]; end
      ST_P1:   begin core_a_s = a_q[7:4]; core_b_s = b_q[3:0]; end
      ST_P2:   begin core_a_s = a_q[3:0]; core_b_s = b_q[7:4]; end
      ST_P3:   begin core_a_s = a_q[7:4]; core_b_s = b_q[7:4]; end
      default: begin core_a_s = 4'h0;     core_b_s = 4'h0;     end
    endcase
  end

  vedic_mul4_comb u_core (
    .a (core_a_s),
    .b (core_b_s),
    .p (pp_s)
  );

  assign acc_sum_s = acc_q + ({8'h00, pp_s} << pp_shift(state_q));

  // Controller next state and datapath updates; abort drops the partial sum.
  always_comb begin
    state_d   = state_q;
    a_d       = a_q;
    b_d       = b_q;
    acc_d     = acc_q;
    product_d = product_q;
    done_d    = 1'b0;
    case (state_q)
      ST_IDLE, ST_DONE: begin
        if (start_i) begin
          state_d = ST_P0;
          a_d     = a_i;
          b_d     = b_i;
          acc_d   = 16'h0000;
        end else begin
          state_d = ST_IDLE;
        end
      end
      ST_P0, ST_P1, ST_P2: begin
        if (abort_i) begin
          state_d = ST_IDLE;
          acc_d   = 16'h0000;
        end else begin
          acc_d = acc_sum_s;
          case (state_q)
            ST_P0:   state_d = ST_P1;
            ST_P1:   state_d = ST_P2;
            default: state_d = ST_P3;
          endcase
        end
      end
      ST_P3: begin
        if (abort_i) begin
          state_d = ST_IDLE;
          acc_d   = 16'h0000;
        end else begin
          state_d   = ST_DONE;
          product_d = acc_sum_s;
          done_d    = 1'b1;
        end
      end
      default: begin
        state_d = ST_IDLE;
        acc_d   = 16'h0000;
      end
    endcase
  end

  // State and datapath registers.
  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      state_q   <= ST_IDLE;
      a_q       <= 8'h00;
      b_q       <= 8'h00;
      acc_q     <= 16'h0000;
      product_q <= 16'h0000;
      done_q    <= 1'b0;
    end else begin
      state_q   <= state_d;
      a_q       <= a_d;
      b_q       <= b_d;
      acc_q     <= acc_d;
      product_q <= product_d;
      done_q    <= done_d;
    end
  end

  assign busy_o    = (state_q == ST_P0) || (state_q == ST_P1) ||
                     (state_q == ST_P2) || (state_q == ST_P3);
  assign done_o    = done_q;
  assign product_o = product_q;

endmodule

// File: tb/tb_vedic_mul8_seq.sv
// Directed self-checking bench for vedic_mul8_seq: latency, products,
// back-to-back issue, ignored start, abort and asynchronous reset.
module tb_vedic_mul8_seq;

  logic        clk_i;
  logic        rst_i;
  logic        start_i;
  logic        abort_i;
  logic [7:0]  a_i;
  logic [7:0]  b_i;
  logic        busy_o;
  logic        done_o;
  logic [15:0] product_o;

  int n_checks = 0;
  int n_fail   = 0;

  vedic_mul8_seq dut (
    .clk_i     (clk_i),
    .rst_i     (rst_i),
    .start_i   (start_i),
    .abort_i   (abort_i),
    .a_i       (a_i),
    .b_i       (b_i),
    .busy_o    (busy_o),
    .done_o    (done_o),
    .product_o (product_o)
  );

  initial clk_i = 1'b0;
  always #5 clk_i = ~clk_i;

  task automatic step();
    @(posedge clk_i);
    #1;
  endtask

  task automatic run_mul(input logic [7:0] av, input logic [7:0] bv,
                         input logic [15:0] expv, input string name);
    int busy_cnt;
    int lat;
    busy_cnt = 0;
    a_i = av; b_i = bv; start_i = 1'b1;
    step();
    start_i = 1'b0; a_i = 8'h5A; b_i = 8'hC3;
    lat = 1;
    while (done_o !== 1'b1 && lat < 12) begin
      if (busy_o === 1'b1) busy_cnt++;
      step();
      lat++;
    end
    n_checks++;
    if (done_o !== 1'b1) begin
      n_fail++; $display("FAIL %s_timeout done=%b required 1", name, done_o);
    end
    n_checks++;
    if (lat != 5) begin
      n_fail++; $display("FAIL %s_latency got %0d required 5", name, lat);
    end
    n_checks++;
    if (busy_cnt != 4) begin
      n_fail++; $display("FAIL %s_busy_cycles got %0d required 4", name, busy_cnt);
    end
    n_checks++;
    if (busy_o !== 1'b0) begin
      n_fail++; $display("FAIL %s_busy_with_done busy=%b required 0", name, busy_o);
    end
    n_checks++;
    if (product_o !== expv) begin
      n_fail++; $display("FAIL %s_product got %h required %h", name, product_o, expv);
    end
    step();
    n_checks++;
    if (done_o !== 1'b0) begin
      n_fail++; $display("FAIL %s_done_pulse done=%b required 0", name, done_o);
    end
    n_checks++;
    if (product_o !== expv) begin
      n_fail++; $display("FAIL %s_product_hold got %h required %h", name, product_o, expv);
    end
  endtask

  task automatic test_reset();
    rst_i = 1'b1; start_i = 1'b0; abort_i = 1'b0; a_i = 8'h00; b_i = 8'h00;
    step();
    step();
    n_checks++;
    if (busy_o !== 1'b0) begin n_fail++; $display("FAIL reset_busy got %b required 0", busy_o); end
    n_checks++;
    if (done_o !== 1'b0) begin n_fail++; $display("FAIL reset_done got %b required 0", done_o); end
    n_checks++;
    if (product_o !== 16'h0000) begin n_fail++; $display("FAIL reset_product got %h required 0000", product_o); end
    rst_i = 1'b0;
    step();
  endtask

  task automatic test_basic();
    run_mul(8'd5, 8'd2, 16'd10, "basic_5x2");
  endtask

  task automatic test_extremes();
    run_mul(8'hFF, 8'hFF, 16'hFE01, "max_ffxff");
    run_mul(8'hAB, 8'hCD, 16'h88EF, "abxcd");
  endtask

  task automatic test_back_to_back();
    logic [7:0]  av [3];
    logic [7:0]  bv [3];
    logic [15:0] ev [3];
    av[0] = 8'h02; bv[0] = 8'h02; ev[0] = 16'd4;
    av[1] = 8'h00; bv[1] = 8'h80; ev[1] = 16'd0;
    av[2] = 8'h10; bv[2] = 8'h10; ev[2] = 16'd256;
    for (int i = 0; i < 3; i++) begin
      a_i = av[i]; b_i = bv[i]; start_i = 1'b1;
      step();
      a_i = 8'hEE; b_i = 8'h77;
      for (int c = 1; c < 5; c++) begin
        n_checks++;
        if (done_o !== 1'b0) begin n_fail++; $display("FAIL b2b_early_done op %0d cycle %0d got %b required 0", i, c, done_o); end
        step();
      end
      n_checks++;
      if (done_o !== 1'b1) begin n_fail++; $display("FAIL b2b_done op %0d got %b required 1", i, done_o); end
      n_checks++;
      if (busy_o !== 1'b0) begin n_fail++; $display("FAIL b2b_busy op %0d got %b required 0", i, busy_o); end
      n_checks++;
      if (product_o !== ev[i]) begin n_fail++; $display("FAIL b2b_product op %0d got %h required %h", i, product_o, ev[i]); end
    end
    start_i = 1'b0;
    step();
    n_checks++;
    if (busy_o !== 1'b0 || done_o !== 1'b0) begin
      n_fail++; $display("FAIL b2b_idle busy=%b done=%b required 0 0", busy_o, done_o);
    end
  endtask

  task automatic test_start_ignored();
    int dones;
    a_i = 8'd6; b_i = 8'd7; start_i = 1'b1;
    step();
    start_i = 1'b0;
    step();
    a_i = 8'hFF; b_i = 8'hFF; start_i = 1'b1;
    step();
    start_i = 1'b0;
    dones = 0;
    for (int c = 3; c <= 9; c++) begin
      if (done_o === 1'b1) begin
        dones++;
        n_checks++;
        if (c != 5) begin n_fail++; $display("FAIL ignore_done_cycle got %0d required 5", c); end
        n_checks++;
        if (product_o !== 16'd42) begin n_fail++; $display("FAIL ignore_product got %h required %h", product_o, 16'd42); end
      end
      step();
    end
    n_checks++;
    if (dones != 1) begin n_fail++; $display("FAIL ignore_done_count got %0d required 1", dones); end
  endtask

  task automatic test_abort();
    int dones;
    a_i = 8'd9; b_i = 8'd9; start_i = 1'b1;
    step();
    start_i = 1'b0;
    step();
    step();
    abort_i = 1'b1;
    n_checks++;
    if (busy_o !== 1'b1) begin n_fail++; $display("FAIL abort_busy_before got %b required 1", busy_o); end
    step();
    abort_i = 1'b0;
    n_checks++;
    if (busy_o !== 1'b0) begin n_fail++; $display("FAIL abort_busy_after got %b required 0", busy_o); end
    dones = 0;
    for (int c = 0; c < 6; c++) begin
      if (done_o === 1'b1) dones++;
      step();
    end
    n_checks++;
    if (dones != 0) begin n_fail++; $display("FAIL abort_done_count got %0d required 0", dones); end
    n_checks++;
    if (product_o !== 16'd42) begin n_fail++; $display("FAIL abort_product_kept got %h required %h", product_o, 16'd42); end
    run_mul(8'd3, 8'd7, 16'd21, "after_abort_3x7");
  endtask

  task automatic test_async_reset();
    int dones;
    a_i = 8'hAB; b_i = 8'h02; start_i = 1'b1;
    step();
    start_i = 1'b0;
    step();
    step();
    step();
    #2;
    rst_i = 1'b1;
    #1;
    n_checks++;
    if (busy_o !== 1'b0) begin n_fail++; $display("FAIL arst_busy got %b required 0", busy_o); end
    n_checks++;
    if (done_o !== 1'b0) begin n_fail++; $display("FAIL arst_done got %b required 0", done_o); end
    n_checks++;
    if (product_o !== 16'h0000) begin n_fail++; $display("FAIL arst_product got %h required 0000", product_o); end
    step();
    rst_i = 1'b0;
    dones = 0;
    for (int c = 0; c < 8; c++) begin
      if (done_o === 1'b1 || busy_o === 1'b1) dones++;
      step();
    end
    n_checks++;
    if (dones != 0) begin n_fail++; $display("FAIL arst_activity_after_release got %0d required 0", dones); end
    run_mul(8'd12, 8'd12, 16'd144, "after_rst_12x12");
  endtask

  initial begin
    test_reset();
    test_basic();
    test_extremes();
    test_back_to_back();
    test_start_ignored();
    test_abort();
    test_async_reset();
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
